// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/LSU memory arbiter: FSM states, bus owner
// and the enable/disable levels used across the pipeline controller.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the shared memory bus: LSU wins ties until fetch has
// been passed over STARVE_LIMIT times in a row, then fetch is forced through.
module mem_arb_grant
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  output logic       grant_o,
  output arb_owner_e owner_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_ifu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    force_ifu    = (starve_cnt_q == LIMIT);
    grant_o      = en_i && (ifu_valid_i || lsu_valid_i);
    owner_o      = OWN_IFU;
    starve_cnt_d = starve_cnt_q;
    if (lsu_valid_i && !(ifu_valid_i && force_ifu)) begin
      owner_o = OWN_LSU;
    end
    // The counter only moves on arbitration cycles; it measures fetch waiting at IDLE.
    if (en_i) begin
      if (!ifu_valid_i || (grant_o && owner_o == OWN_IFU)) begin
        starve_cnt_d = '0;
      end else if (grant_o && owner_o == OWN_LSU && !force_ifu) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the LSU,
// one outstanding transaction at a time, with flush-based fetch discard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  input  logic                ifu_flush_i,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                if_stall_o
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_owner_e        grant_owner;
  logic              grant_valid;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              discard_q, discard_d;
  logic              active_q, active_d;
  logic              out_en, idle_en, ifu_cand;

  // active_q keeps every output quiet for one cycle after reset is released.
  assign active_d = ENABLE;
  assign out_en   = rst_n && active_q;
  assign idle_en  = out_en && (state_q == ST_IDLE);
  assign ifu_cand = ifu_req_valid_i && !ifu_flush_i;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (idle_en),
    .ifu_valid_i(ifu_cand),
    .lsu_valid_i(lsu_req_valid_i),
    .grant_o    (grant_valid),
    .owner_o    (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IFU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      discard_q <= 1'b0;
      active_q  <= DISABLE;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      discard_q <= discard_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    discard_d       = discard_q;
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    ifu_rvalid_o    = 1'b0;
    ifu_rdata_o     = '0;
    lsu_rvalid_o    = 1'b0;
    lsu_rdata_o     = '0;
    m_valid_o       = 1'b0;
    m_we_o          = 1'b0;
    m_addr_o        = '0;
    m_wdata_o       = '0;
    m_wstrb_o       = '0;
    if (out_en) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_d   = grant_owner;
            state_d   = ST_ISSUE;
            discard_d = 1'b0;
            if (grant_owner == OWN_LSU) begin
              lsu_req_ready_o = 1'b1;
              we_d            = lsu_we_i;
              addr_d          = lsu_addr_i;
              wdata_d         = lsu_wdata_i;
              wstrb_d         = lsu_wstrb_i;
            end else begin
              ifu_req_ready_o = 1'b1;
              we_d            = 1'b0;
              addr_d          = ifu_addr_i;
              wdata_d         = '0;
              wstrb_d         = '0;
            end
          end
        end
        ST_ISSUE: begin
          m_valid_o = 1'b1;
          m_we_o    = we_q;
          m_addr_o  = addr_q;
          m_wdata_o = wdata_q;
          m_wstrb_o = wstrb_q;
          if (m_ready_i) begin
            state_d = ST_WAIT;
          end
          if (ifu_flush_i && owner_q == OWN_IFU) begin
            discard_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (ifu_flush_i && owner_q == OWN_IFU) begin
            discard_d = 1'b1;
          end
          if (m_rvalid_i) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
            if (owner_q == OWN_LSU) begin
              lsu_rvalid_o = 1'b1;
              lsu_rdata_o  = we_q ? '0 : m_rdata_i;
            end else if (!discard_q) begin
              ifu_rvalid_o = 1'b1;
              ifu_rdata_o  = m_rdata_i;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign if_stall_o = out_en && ifu_req_valid_i && !ifu_req_ready_o;

endmodule
